// File: rtl/arm_pkg.sv
// Shared MEM-stage definitions: SRAM controller states and external SRAM geometry.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [31:0] DATA_BASE_ADDR = 32'd1024;
    localparam int          SRAM_ADDR_W    = 18;
    localparam int          SRAM_DQ_W      = 16;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Splits a 32-bit load/store into two 16-bit SRAM phases of WAIT_STATES cycles each; 2W+1 cycle latency.
// Backpressure: ready is low while a request is held and the transaction has not reached DONE.
module sram_mem_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 5,
    parameter logic [31:0] DATA_BASE   = DATA_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DQ_W-1:0]   sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
    output logic                   sram_we_n
);

    localparam int               CNT_W      = $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_STATES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    mem_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_wr_q, op_wr_d;
    logic [16:0]            idx_q, idx_d;
    logic [15:0]            wdata_hi_q, wdata_hi_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DQ_W-1:0]   dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;

    logic        req;
    logic [16:0] idx_in;

    assign req    = rd_en | wr_en;
    // Word index wraps modulo 2^17; the byte offset bits are discarded.
    assign idx_in = 17'((addr - DATA_BASE) >> 2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        idx_d       = idx_q;
        wdata_hi_d  = wdata_hi_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = LO;
                    op_wr_d     = wr_en;
                    idx_d       = idx_in;
                    wdata_hi_d  = wdata[31:16];
                    cnt_d       = CNT_RELOAD;
                    sram_addr_d = {idx_in, 1'b0};
                    if (wr_en) begin
                        dq_out_d = wdata[15:0];
                    end
                    dq_oe_d     = wr_en;
                    we_n_d      = ~wr_en;
                end
            end
            LO: begin
                if (cnt_q == '0) begin
                    if (!op_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    state_d     = HI;
                    cnt_d       = CNT_RELOAD;
                    sram_addr_d = {idx_q, 1'b1};
                    if (op_wr_q) begin
                        dq_out_d = wdata_hi_q;
                    end
                    dq_oe_d     = op_wr_q;
                    // One high cycle on we_n lets the SRAM latch the low half.
                    we_n_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HI: begin
                if (cnt_q == '0) begin
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    state_d = DONE;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    we_n_d = ~op_wr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                dq_oe_d = 1'b0;
                we_n_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_hi_q  <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            idx_q       <= idx_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = ~req | (state_q == DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: directed loads/stores against a behavioural SRAM model.
module tb_sram_mem_ctrl;
    import arm_pkg::*;

    localparam int W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    sram_mem_ctrl #(.WAIT_STATES(W), .DATA_BASE(32'd1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:63];
    assign sram_dq_in = mem[sram_addr[5:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
        logic [7:0]  len;
        logic [7:0]  gap;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] done_q[$];
    logic [31:0] exp_rdata;

    // Completion monitor: latency of the freeze and the load word at DONE.
    int lat_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            lat_cnt = 0;
        end else if (rd_en | wr_en) begin
            if (!ready) begin
                lat_cnt++;
            end else begin
                chk("ready_latency", lat_cnt, 2 * W + 1);
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_q: unexpected completion, rdata %h", rdata);
                end else begin
                    chk("rdata", rdata, done_q.pop_front());
                end
                lat_cnt = 0;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // SRAM write-pulse monitor and memory model.
    logic        in_pulse = 1'b0;
    int          plen = 0;
    int          gap = 0;
    int          cap_gap = 0;
    logic [17:0] cap_a;
    logic [15:0] cap_d;
    wr_exp_t     e;
    always @(negedge clk) begin
        if (!rst) begin
            in_pulse = 1'b0;
            gap      = 0;
        end else if (!sram_we_n) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                plen     = 0;
                cap_a    = sram_addr;
                cap_d    = sram_dq_out;
                cap_gap  = gap;
                chk("dq_oe_in_write", sram_dq_oe, 1);
            end
            plen++;
            mem[sram_addr[5:0]] = sram_dq_out;
        end else begin
            if (in_pulse) begin
                in_pulse = 1'b0;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_q: unexpected write addr %h data %h", cap_a, cap_d);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", cap_a, e.a);
                    chk("wr_data", cap_d, e.d);
                    chk("we_n_low_len", plen, e.len);
                    if (e.gap != 0) chk("we_n_high_gap", cap_gap, e.gap);
                end
                gap = 0;
            end
            gap++;
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk);
        #1;
        rd_en = rd;
        wr_en = wr;
        addr  = a;
        wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        if (!ready) chk("req_timeout", ready, 1);
    endtask

    task automatic push_writes(input logic [17:0] lo, input logic [31:0] d);
        wr_q.push_back('{a: lo, d: d[15:0], len: 8'(W), gap: 8'd0});
        wr_q.push_back('{a: lo + 18'd1, d: d[31:16], len: 8'(W - 1), gap: 8'd1});
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [17:0] lo);
        push_writes(lo, d);
        done_q.push_back(exp_rdata);
        do_req(1'b0, 1'b1, a, d);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        exp_rdata = exp;
        done_q.push_back(exp);
        do_req(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[4] = 16'h1234;
        mem[5] = 16'hABCD;
        exp_rdata = 32'h0;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", ready, 1);

        store(32'd1028, 32'hDEADBEEF, 18'd2);
        idle(3);
        load(32'd1028, 32'hDEADBEEF);
        idle(2);
        store(32'd1036, 32'h55667788, 18'd6);
        idle(2);

        // Back-to-back: each new request lands in the IDLE cycle right after DONE.
        load(32'd1032, 32'hABCD1234);
        store(32'd1044, 32'hCAFEF00D, 18'd10);
        load(32'd1044, 32'hCAFEF00D);
        load(32'd1036, 32'h55667788);
        idle(2);

        push_writes(18'd0, 32'h0BAD0BAD);
        done_q.push_back(exp_rdata);
        do_req(1'b1, 1'b1, 32'd1024, 32'h0BAD0BAD);
        idle(2);
        load(32'd1024, 32'h0BAD0BAD);
        idle(2);

        // Reset in the middle of the low-half write phase.
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        addr  = 32'd1040;
        wdata = 32'h11112222;
        repeat (3) @(negedge clk);
        chk("we_n_low_before_rst", sram_we_n, 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_dq_oe", sram_dq_oe, 0);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        chk("abort_rdata", rdata, 0);
        wr_en = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_rdata = 32'h0;
        load(32'd1032, 32'hABCD1234);
        idle(3);

        chk("wr_q_drained", wr_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
